// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns (with don't-care bits) and the
// control bundle carried from the ID stage to ID/EX.
package legv8_pkg;

  typedef struct packed {
    logic       Reg2Loc;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       BranchNZ;
    logic       Uncond;
    logic [1:0] ALUOp;
    logic       Illegal;
  } ctrl_t;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100???;
  localparam logic [10:0] OP_BCOND = 11'b01010100???;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
  localparam logic [10:0] OP_B     = 11'b000101?????;
  localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OP_ADDIS = 11'b1011000100?;
  localparam logic [10:0] OP_SUBI  = 11'b1101000100?;
  localparam logic [10:0] OP_SUBIS = 11'b1111000100?;

  // Bit order: Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch BranchNZ Uncond ALUOp[1:0] Illegal
  localparam ctrl_t CTRL_NOP  = ctrl_t'(12'b0000_0000_0000);
  localparam ctrl_t CTRL_RFMT = ctrl_t'(12'b0001_0000_0100);
  localparam ctrl_t CTRL_LDUR = ctrl_t'(12'b0111_1000_0000);
  localparam ctrl_t CTRL_STUR = ctrl_t'(12'b1100_0100_0000);
  localparam ctrl_t CTRL_CBZ  = ctrl_t'(12'b1000_0010_0010);
  localparam ctrl_t CTRL_CBNZ = ctrl_t'(12'b1000_0011_0010);
  localparam ctrl_t CTRL_B    = ctrl_t'(12'b0000_0010_1000);
  localparam ctrl_t CTRL_IFMT = ctrl_t'(12'b0101_0000_0110);
  localparam ctrl_t CTRL_ILL  = ctrl_t'(12'b0000_0000_0001);

endpackage

// File: rtl/maindec_comb.sv
// Combinational LEGv8 main decoder: 11-bit opcode to control bundle.
// Extended opcodes (B, CBNZ, AND, ORR) decode only when EXT_EN is set.
module maindec_comb
  import legv8_pkg::*;
#(
  parameter bit EXT_EN = 1'b1
) (
  input  logic [10:0] op,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = CTRL_ILL;
    casez (op)
      OP_ADD, OP_SUB, OP_ADDS, OP_SUBS:     ctrl = CTRL_RFMT;
      OP_AND, OP_ORR:                       ctrl = EXT_EN ? CTRL_RFMT : CTRL_ILL;
      OP_LDUR:                              ctrl = CTRL_LDUR;
      OP_STUR:                              ctrl = CTRL_STUR;
      OP_CBZ, OP_BCOND:                     ctrl = CTRL_CBZ;
      OP_CBNZ:                              ctrl = EXT_EN ? CTRL_CBNZ : CTRL_ILL;
      OP_B:                                 ctrl = EXT_EN ? CTRL_B : CTRL_ILL;
      OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS: ctrl = CTRL_IFMT;
      default:                              ctrl = CTRL_ILL;
    endcase
  end

endmodule

// File: rtl/maindec_pipe.sv
// Registered, handshaked ID-stage main decoder. Decodes on accept, presents the
// bundle one cycle later; optional skid entry keeps in_ready off the out_ready path.
module maindec_pipe
  import legv8_pkg::*;
#(
  parameter bit EXT_EN  = 1'b1,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      Op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             BranchNZ,
  output logic             Uncond,
  output logic [1:0]       ALUOp,
  output logic             Illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: decode at the input
  ctrl_t ctrl_p0;

  maindec_comb #(.EXT_EN(EXT_EN)) u_dec (
    .op   (Op),
    .ctrl (ctrl_p0)
  );

  // Stage p1: head register plus overflow (skid) register
  logic  vld_p1;
  logic  skid_vld_p1;
  ctrl_t ctrl_p1;
  ctrl_t skid_p1;
  ctrl_t ctrl_out;
  logic  accept;
  logic  load_main;

  assign in_ready  = SKID_EN ? ~skid_vld_p1 : (~vld_p1 | out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  // Head is free to take a new entry when empty or leaving this edge.
  assign load_main = ~vld_p1 | out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1      <= load_main ? (skid_vld_p1 | accept) : 1'b1;
        skid_vld_p1 <= load_main ? 1'b0 : (skid_vld_p1 | accept);
      end
      if (accept && ctrl_p0.Illegal)
        illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (load_main)
      ctrl_p1 <= skid_vld_p1 ? skid_p1 : ctrl_p0;
    if (!load_main && accept)
      skid_p1 <= ctrl_p0;
  end

  // Masking by valid makes reset clear the visible controls without resetting data.
  assign ctrl_out  = vld_p1 ? ctrl_p1 : CTRL_NOP;
  assign out_valid = vld_p1;
  assign Reg2Loc   = ctrl_out.Reg2Loc;
  assign ALUSrc    = ctrl_out.ALUSrc;
  assign MemtoReg  = ctrl_out.MemtoReg;
  assign RegWrite  = ctrl_out.RegWrite;
  assign MemRead   = ctrl_out.MemRead;
  assign MemWrite  = ctrl_out.MemWrite;
  assign Branch    = ctrl_out.Branch;
  assign BranchNZ  = ctrl_out.BranchNZ;
  assign Uncond    = ctrl_out.Uncond;
  assign ALUOp     = ctrl_out.ALUOp;
  assign Illegal   = ctrl_out.Illegal;

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: two instances (extended+skid+2-bit counter,
// base+no-skid+16-bit counter) share stimulus and are checked against a decode model.
module tb_maindec_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] op = '0;

  logic [11:0] b0, b1;
  logic        ir0, ir1, ov0, ov1;
  logic [1:0]  c0;
  logic [15:0] c1;

  logic        ir [2];
  logic        ov [2];
  logic [11:0] bun [2];
  logic [15:0] cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maindec_pipe #(.EXT_EN(1'b1), .SKID_EN(1'b1), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .Op(op), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready),
    .Reg2Loc(b0[11]), .ALUSrc(b0[10]), .MemtoReg(b0[9]), .RegWrite(b0[8]), .MemRead(b0[7]),
    .MemWrite(b0[6]), .Branch(b0[5]), .BranchNZ(b0[4]), .Uncond(b0[3]), .ALUOp(b0[2:1]),
    .Illegal(b0[0]), .illegal_cnt(c0)
  );

  maindec_pipe #(.EXT_EN(1'b0), .SKID_EN(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .Op(op), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready),
    .Reg2Loc(b1[11]), .ALUSrc(b1[10]), .MemtoReg(b1[9]), .RegWrite(b1[8]), .MemRead(b1[7]),
    .MemWrite(b1[6]), .Branch(b1[5]), .BranchNZ(b1[4]), .Uncond(b1[3]), .ALUOp(b1[2:1]),
    .Illegal(b1[0]), .illegal_cnt(c1)
  );

  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign bun[0] = b0;
  assign bun[1] = b1;
  assign cnt[0] = {14'b0, c0};
  assign cnt[1] = c1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table; result packed as
  // {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNZ,Uncond,ALUOp,Illegal}.
  function automatic logic [11:0] ref_ctrl(input bit ext, input logic [10:0] o);
    logic r2l, src, m2r, rw, mr, mw, br, bnz, unc, ill;
    logic [1:0] aop;
    {r2l, src, m2r, rw, mr, mw, br, bnz, unc, ill} = '0;
    aop = 2'd0;
    if (o == 11'h458 || o == 11'h658 || o == 11'h558 || o == 11'h758 ||
        (ext && (o == 11'h450 || o == 11'h550))) begin
      rw = 1; aop = 2'd2;
    end else if (o == 11'h7C2) begin
      src = 1; m2r = 1; rw = 1; mr = 1;
    end else if (o == 11'h7C0) begin
      r2l = 1; src = 1; mw = 1;
    end else if (o[10:3] == 8'hB4 || o[10:3] == 8'h54 || (ext && o[10:3] == 8'hB5)) begin
      r2l = 1; br = 1; aop = 2'd1; bnz = (o[10:3] == 8'hB5);
    end else if (ext && o[10:5] == 6'd5) begin
      br = 1; unc = 1;
    end else if (o[10:1] == 10'h244 || o[10:1] == 10'h2C4 ||
                 o[10:1] == 10'h344 || o[10:1] == 10'h3C4) begin
      src = 1; rw = 1; aop = 2'd3;
    end else begin
      ill = 1;
    end
    return {r2l, src, m2r, rw, mr, mw, br, bnz, unc, aop, ill};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : sb
    localparam bit EXT  = (g == 0);
    localparam bit SKID = (g == 0);
    localparam int MAXC = (g == 0) ? 3 : 65535;
    logic [11:0] q[$];
    int          mcnt = 0;
    bit          acc_now = 0;

    // Issue side: record the expected bundle for every accepted opcode.
    always @(posedge clk) begin
      logic [11:0] e;
      #3;
      if (!reset) begin
        q.delete();
        mcnt = 0;
        acc_now = 0;
      end else begin
        chk($sformatf("illegal_cnt[%0d]", g), cnt[g], mcnt);
        acc_now = in_valid && ir[g] && !flush;
        if (acc_now) begin
          e = ref_ctrl(EXT, op);
          q.push_back(e);
          if (e[0] && mcnt < MAXC) mcnt++;
        end
      end
    end

    // Monitor side: compare what the DUT presents against the queue head.
    always @(negedge clk) begin
      int held;
      if (!reset) begin
        q.delete();
      end else begin
        held = q.size() - int'(acc_now);
        chk($sformatf("out_valid[%0d]", g), ov[g], held > 0);
        chk($sformatf("in_ready[%0d]", g), ir[g], SKID ? (held < 2) : (held == 0 || out_ready));
        if (ov[g] && held > 0) begin
          chk($sformatf("bundle[%0d]", g), bun[g], q[0]);
          if (out_ready) void'(q.pop_front());
        end
        if (flush) q.delete();
      end
    end
  end

  task automatic drive(input logic v, input logic [10:0] o, input logic f, input logic r);
    @(posedge clk);
    #1;
    in_valid = v;
    op = o;
    flush = f;
    out_ready = r;
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] w;
    w = 11'($urandom);
    case ($urandom_range(0, 15))
      0:  return 11'h458;
      1:  return 11'h658;
      2:  return 11'h558;
      3:  return 11'h758;
      4:  return 11'h450;
      5:  return 11'h550;
      6:  return 11'h7C2;
      7:  return 11'h7C0;
      8:  return {8'hB4, w[2:0]};
      9:  return {8'h54, w[2:0]};
      10: return {8'hB5, w[2:0]};
      11: return {6'd5, w[4:0]};
      12: return {10'h244, w[0]};
      13: return {10'h344, w[0]};
      14: return {10'h3C4, w[0]};
      default: return w;
    endcase
  endfunction

  logic [10:0] ill_ops [4];

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_out_valid0", ov0, 0);
    chk("reset_out_valid1", ov1, 0);
    chk("reset_ctrl0", b0, 0);
    chk("reset_in_ready0", ir0, 1);
    chk("reset_cnt0", c0, 0);
    chk("reset_cnt1", c1, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    drive(1, 11'b11111000010, 0, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("ldur_valid", ov0, 1);
    chk("ldur_ctrl", b0, 12'b0111_1000_0000);

    drive(1, 11'b10110101000, 0, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("cbnz_ext_ctrl", b0, 12'b1000_0011_0010);
    chk("cbnz_noext_ctrl", b1, 12'b0000_0000_0001);
    chk("cbnz_noext_cnt", c1, 1);

    drive(1, 11'b10001011000, 0, 0);
    drive(1, 11'b11010001000, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("stall_in_ready", ir0, 0);
    chk("stall_valid", ov0, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("order_add", b0, 12'b0001_0000_0100);
    @(negedge clk);
    chk("order_subi", b0, 12'b0101_0000_0110);
    drive(0, 0, 0, 1);

    ill_ops[0] = 11'h7FF; ill_ops[1] = 11'h000; ill_ops[2] = 11'h6AA; ill_ops[3] = 11'h7FF;
    for (int i = 0; i < 4; i++) begin
      drive(1, ill_ops[i], 0, 1);
      @(negedge clk);
      chk($sformatf("sat_cnt_step%0d", i), c0, i);
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("sat_cnt_hold", c0, 3);

    drive(1, 11'b10001011000, 0, 0);
    drive(1, 11'b11111000010, 0, 0);
    drive(1, 11'b00010100000, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("flush_valid0", ov0, 0);
    chk("flush_in_ready0", ir0, 1);
    chk("flush_valid1", ov1, 0);
    chk("flush_cnt_kept", c0, 3);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("flush_b_dropped", ov0, 0);

    drive(1, 11'b10010001000, 0, 0);
    drive(0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid0", ov0, 0);
    chk("async_rst_ctrl0", b0, 0);
    chk("async_rst_valid1", ov1, 0);
    chk("async_rst_ctrl1", b1, 0);
    chk("async_rst_cnt0", c0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1, 11'b11111000000, 0, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("stur_ctrl0", b0, 12'b1100_0100_0000);
    chk("stur_ctrl1", b1, 12'b1100_0100_0000);

    for (int i = 0; i < 800; i++)
      drive(($urandom_range(0, 3) != 0), rand_op(), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    @(negedge clk);
    chk("drain_q0", sb[0].q.size(), 0);
    chk("drain_q1", sb[1].q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maindec_pipe.md
Name: maindec_pipe

Overview:
- Registered, handshaked successor to the combinational main decoder, forming the ID-stage control unit for the pipelined LEGv8 core.
- Accepts an 11-bit opcode with valid/ready and emits the full control bundle one cycle later.
- Adds unconditional B, CBNZ and logical R-format decode, plus illegal-opcode flagging and counting.
- Supports pipeline flush and downstream stall, with an optional skid buffer so in_ready is registered.

Parameters:
EXT_EN, 1, 1 enables decode of B, CBNZ, AND, ORR; 0 treats them as illegal.
SKID_EN, 1, 1 uses a 2-entry skid buffer with registered in_ready; 0 uses a single register with combinational in_ready.
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  Op is valid
in_ready  out  1  block accepts Op this cycle
Op  in  11  instruction bits [31:21]
flush  in  1  discard all held and incoming entries
out_valid  out  1  control bundle valid
out_ready  in  1  downstream (ID/EX) accepts the bundle
Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  classic control signals
BranchNZ  out  1  branch on register non-zero (CBNZ)
Uncond  out  1  unconditional branch (B)
ALUOp  out  2  ALU control class
Illegal  out  1  opcode not in table; all other controls 0
illegal_cnt  out  CNT_W  count of accepted illegal opcodes, saturating

Behaviour:
- Reset (reset=0, async):
  - out_valid=0 and all control outputs 0.
  - illegal_cnt=0.
  - in_ready=1 when SKID_EN=1.
- Accept: in_valid & in_ready & ~flush. Handshake: out_valid & out_ready. Latency is 1 cycle from accept to out_valid.
- Decode table (ctrl order Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp):
  - R-format, ctrl 0_0_0_1_0_0_0_10: ADD 10001011000, SUB 11001011000, ADDS 10101011000, SUBS 11101011000; AND 10001010000 and ORR 10101010000 when EXT_EN.
  - LDUR 11111000010, ctrl 0_1_1_1_1_0_0_00.
  - STUR 11111000000, ctrl 1_1_0_0_0_1_0_00.
  - CBZ 10110100???, ctrl 1_0_0_0_0_0_1_01. B.cond 01010100??? decodes the same.
  - CBNZ 10110101??? (EXT_EN), as CBZ plus BranchNZ=1.
  - B 000101????? (EXT_EN), ctrl all 0 except Branch=1 and Uncond=1, ALUOp=00.
  - I-format, ctrl 0_1_0_1_0_0_0_11: ADDI 1001000100?, ADDIS 1011000100?, SUBI 1101000100?, SUBIS 1111000100?.
  - Anything else: Illegal=1, every other control 0, out_valid still asserted. illegal_cnt increments on accept and holds at 2^CNT_W-1.
- SKID_EN=1:
  - Main register holds the head entry; the skid register holds one overflow entry.
  - in_ready (registered) = skid register empty.
  - Accept while the main register is occupied and not draining: entry goes to the skid register, and in_ready drops next cycle.
  - When the main register drains, the skid entry moves to main the same edge, and in_ready rises next cycle.
- SKID_EN=0: in_ready = ~out_valid | out_ready (combinational).
- Outputs hold stable while out_valid & ~out_ready.
- flush=1:
  - Next edge clears both entries: out_valid=0, skid empty, in_ready=1.
  - An input presented the same cycle is not accepted and not counted.
  - illegal_cnt is not cleared.
- A simultaneous accept and drain with one entry held replaces the main entry and leaves the skid register empty.
- Reset asserted mid-operation drops all entries immediately.

Decomposition:
- Package legv8_pkg holds:
  - opcode pattern constants (OP_ADD, OP_LDUR, OP_CBZ, ...);
  - packed struct ctrl_t {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNZ, Uncond, ALUOp[1:0], Illegal};
  - CTRL_NOP constant.
- Sub-module maindec_comb: purely combinational Op -> ctrl_t using casez, parametrised by EXT_EN, instantiated once in front of the buffer.

Test Plan:
- Reset then LDUR 11111000010, out_ready=1 -> next cycle out_valid=1, ctrl 0_1_1_1_1_0_0_00, Illegal=0.
- Op 10110101000 with EXT_EN=1 -> Branch=1, BranchNZ=1, Reg2Loc=1, ALUOp=01. Same with EXT_EN=0 -> Illegal=1, illegal_cnt +1.
- Hold out_ready=0 and send ADD then SUBI (SKID_EN=1):
  - both are accepted and in_ready drops to 0;
  - releasing out_ready yields ADD (ALUOp 10) then SUBI (ALUOp 11) in order, with no loss or duplication.
- Send 3 illegal opcodes with CNT_W=2 -> illegal_cnt 1,2,3; a 4th stays at 3.
- With two entries buffered, pulse flush together with in_valid=1 (B) -> next cycle out_valid=0, in_ready=1, B not delivered, illegal_cnt unchanged.
- Drive reset low mid-stall with out_valid=1 -> out_valid and all controls 0 immediately (before the clock edge); after release, STUR decodes 1_1_0_0_0_1_0_00.
